// File: rtl/clz_arbiter.sv
// Two-requester front end sharing one nibble-serial count-leading-zeros unit.
// Round-robin grant on ties; one operand in flight at a time.
module clz_arbiter #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [5:0]  rsp_clz,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        id_q, id_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        found_q, found_d;
  logic        last_grant_q, last_grant_d;

  logic        grant1;
  logic        accept;
  logic [3:0]  nibble;
  logic        nib_nz;
  logic        scan_end;

  function automatic logic [5:0] lz4(input logic [3:0] n);
    if (n[3])      return 6'd0;
    else if (n[2]) return 6'd1;
    else if (n[1]) return 6'd2;
    else           return 6'd3;
  endfunction

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign grant1   = req1_valid && (!req0_valid || !last_grant_q);
  assign accept   = req0_ready || req1_ready;
  assign nibble   = data_q[{idx_q, 2'b00} +: 4];
  assign nib_nz   = (nibble != 4'd0);
  assign scan_end = (idx_q == 3'd0) || (EARLY_EXIT && nib_nz);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = SCAN;
      SCAN:    if (scan_end)  state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = (state_q == IDLE) && !reset && req0_valid && !grant1;
    req1_ready = (state_q == IDLE) && !reset && grant1;
    rsp_valid  = (state_q == DONE);
    rsp_id     = id_q;
    rsp_clz    = cnt_q;
  end

  // Datapath next values
  always_comb begin
    data_d       = data_q;
    id_d         = id_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    found_d      = found_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      data_d       = req1_ready ? req1_data : req0_data;
      id_d         = req1_ready;
      idx_d        = 3'd7;
      cnt_d        = 6'd0;
      found_d      = 1'b0;
      last_grant_d = req1_ready;
    end else if (state_q == SCAN) begin
      // Once a set bit has been seen, later nibbles must not add to the count.
      if (!found_q) begin
        cnt_d   = nib_nz ? cnt_q + lz4(nibble) : cnt_q + 6'd4;
        found_d = nib_nz;
      end
      if (idx_q != 3'd0) idx_d = idx_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= 32'd0;
      id_q         <= 1'b0;
      idx_q        <= 3'd7;
      cnt_q        <= 6'd0;
      found_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      data_q       <= data_d;
      id_q         <= id_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      found_q      <= found_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: doc/clz_arbiter.md
CLZ_ARBITER -- requirements
Module: clz_arbiter

Interface
REQ-001 Parameter EARLY_EXIT, default 1: 1 means the scan stops at the first non-zero nibble; 0 means the scan always runs 8 cycles.
REQ-002 Clocking and reset SHALL be one clock with synchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operand.
REQ-006 req0_data  input  32  requester 0 operand.
REQ-007 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has an operand.
REQ-009 req1_data  input  32  requester 1 operand.
REQ-010 req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 rsp_clz  output  6  leading-zero count, range 0..32.
REQ-014 rsp_ready  input  1  consumer takes the result.

Function
REQ-015 The block SHALL share one nibble-serial CLZ datapath between two requesters, using an FSM with states IDLE, SCAN and DONE.
REQ-016 reqN_ready SHALL be combinational and high only in IDLE, for the granted requester only.
  - At most one ready is high per cycle.
  - No ready is high in SCAN or DONE.
REQ-017 Grant in IDLE SHALL follow these rules:
  - Only one valid requester: it is granted.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates on each accept.
REQ-018 On accept (reqN_valid && reqN_ready) in cycle T, the block SHALL:
  - latch the data and N;
  - set the nibble index to 7 (bits 31:28) and the count to 0;
  - go to SCAN.
REQ-019 Each SCAN cycle SHALL examine the nibble at the current index, MSB first:
  - Zero nibble: count += 4, index -= 1.
  - Non-zero nibble: count += lz4(nibble), where lz4 gives 1→3, 2..3→2, 4..7→1, 8..15→0.
REQ-020 With EARLY_EXIT=1, the FSM SHALL go to DONE after the first non-zero nibble, or after index 0 if all nibbles are zero.
  - Scan length k = (position of the first non-zero nibble counted from the MSB) + 1, range 1..8.
  - An all-zero operand gives k=8 and count 32.
REQ-021 With EARLY_EXIT=0, the FSM SHALL run exactly 8 SCAN cycles.
  - Nibbles after the first non-zero nibble do not change the count.
  - The result is identical to EARLY_EXIT=1.
REQ-022 SCAN SHALL occupy cycles T+1..T+k, and rsp_valid SHALL rise in cycle T+k+1.
REQ-023 In DONE, rsp_valid SHALL be high and rsp_id/rsp_clz SHALL be held stable until the cycle in which rsp_valid && rsp_ready.
REQ-024 On the DONE handshake the FSM SHALL go to IDLE; no new accept occurs in the handshake cycle, so the minimum accept-to-accept spacing is k+2 cycles.
REQ-025 Arithmetic SHALL be unsigned, with a 6-bit count that never exceeds 32 and never wraps.
REQ-026 Data and valid of a requester that is not granted SHALL be ignored; the requester keeps them asserted until it sees ready.
REQ-027 rsp_id and rsp_clz SHALL be don't-care while rsp_valid is low, but they SHALL NOT change while rsp_valid is high.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set:
  - state = IDLE, rsp_valid = 0, rsp_id = 0, rsp_clz = 0;
  - nibble index = 7, count = 0;
  - last_grant = 1, so requester 0 wins the first tie.
REQ-029 Reset during SCAN or DONE SHALL discard the in-flight operation with no response; accept is possible in the first cycle after reset is released.
REQ-030 reqN_ready SHALL be low in any cycle in which reset is high.

Verification
REQ-031 Single requester, MSB set: req0 sends 0x80000000 with EARLY_EXIT=1 → k=1, rsp_valid at T+2, rsp_id=0, rsp_clz=0.
REQ-032 Mid-range operand: req1 sends 0x00000ABC → k=6, rsp_valid at T+7, rsp_id=1, rsp_clz=20.
REQ-033 Zero and sweep:
  - 0x00000000 → rsp_clz=32, rsp_valid at T+9.
  - 0x00000001 → 31.
  - 0x0F000000 → 4.
  - With EARLY_EXIT=0, 0x80000000 → rsp_clz=0, rsp_valid at T+9.
REQ-034 Fairness: both requesters held valid from reset with rsp_ready=1 → grant order 0,1,0,1, with exactly one ready per accept.
REQ-035 Backpressure: rsp_ready held low for 5 cycles in DONE → rsp_valid, rsp_id and rsp_clz stable, both readys low; on release the handshake completes and the next accept occurs the following cycle.
REQ-036 Reset mid-SCAN: assert reset in cycle T+3 of a k=8 scan → next cycle rsp_valid=0, no response for that operand, and req0 wins if both requesters are valid.
